// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I execute stage: ALU operation codes, XLEN,
// and the ID/EX and EX/MEM pipeline register layouts.
package alu_pkg;

  localparam int XLEN = 32;

  // These values must stay in step with the ALU decoder's ALU_* defines
  localparam logic [3:0] ALU_SUM  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_ROR  = 4'd10;

  typedef struct packed {
    logic            valid;
    logic [3:0]      ALUControl;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            ALUSrc;
    logic            RegWrite;
    logic            MemWrite;
    logic            Branch;
    logic            Jump;
    logic [1:0]      ResultSrc;
  } id_ex_t;

  typedef struct packed {
    logic            valid;
    logic            RegWrite;
    logic            MemWrite;
    logic [1:0]      ResultSrc;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
  } ex_mem_t;

endpackage

// File: rtl/alu_execute_stage_if.sv
// Bundle of every signal crossing the execute stage boundary except clock and
// reset; master is the surrounding pipeline, slave is the execute stage.
interface alu_execute_stage_if;
  import alu_pkg::*;

  logic            id_valid;
  logic [3:0]      id_ALUControl;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_ALUSrc;
  logic            id_RegWrite;
  logic            id_MemWrite;
  logic            id_Branch;
  logic            id_Jump;
  logic [1:0]      id_ResultSrc;

  logic            stall_e;
  logic            flush_e;

  logic [4:0]      mem_rd;
  logic            mem_RegWrite;
  logic [XLEN-1:0] mem_fwd;
  logic [4:0]      wb_rd;
  logic            wb_RegWrite;
  logic [XLEN-1:0] wb_result;

  logic [4:0]      e_rs1;
  logic [4:0]      e_rs2;
  logic [4:0]      e_rd;
  logic            e_ResultSrc0;
  logic            pc_src_e;
  logic [XLEN-1:0] pc_target_e;
  logic            illegal_op_e;

  logic            m_valid;
  logic            m_RegWrite;
  logic            m_MemWrite;
  logic [1:0]      m_ResultSrc;
  logic [XLEN-1:0] m_alu_result;
  logic [XLEN-1:0] m_write_data;
  logic [XLEN-1:0] m_pc_plus4;
  logic [4:0]      m_rd;

  modport master (
    output id_valid, id_ALUControl, id_rs1_data, id_rs2_data, id_imm, id_pc,
           id_rs1, id_rs2, id_rd, id_ALUSrc, id_RegWrite, id_MemWrite,
           id_Branch, id_Jump, id_ResultSrc, stall_e, flush_e,
           mem_rd, mem_RegWrite, mem_fwd, wb_rd, wb_RegWrite, wb_result,
    input  e_rs1, e_rs2, e_rd, e_ResultSrc0, pc_src_e, pc_target_e, illegal_op_e,
           m_valid, m_RegWrite, m_MemWrite, m_ResultSrc, m_alu_result,
           m_write_data, m_pc_plus4, m_rd
  );

  modport slave (
    input  id_valid, id_ALUControl, id_rs1_data, id_rs2_data, id_imm, id_pc,
           id_rs1, id_rs2, id_rd, id_ALUSrc, id_RegWrite, id_MemWrite,
           id_Branch, id_Jump, id_ResultSrc, stall_e, flush_e,
           mem_rd, mem_RegWrite, mem_fwd, wb_rd, wb_RegWrite, wb_result,
    output e_rs1, e_rs2, e_rd, e_ResultSrc0, pc_src_e, pc_target_e, illegal_op_e,
           m_valid, m_RegWrite, m_MemWrite, m_ResultSrc, m_alu_result,
           m_write_data, m_pc_plus4, m_rd
  );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit RV32I ALU. Rotate-right is only decoded when the
// ALU_ROR_EN macro is defined; otherwise ALU_ROR is reported as illegal.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ALUControl,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (ALUControl)
      ALU_SUM:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
`ifdef ALU_ROR_EN
      // A left shift by 32 yields zero, so shamt == 0 needs no special case
      ALU_ROR:  result = (a >> shamt) | (a << (6'd32 - {1'b0, shamt}));
`endif
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_execute_stage.sv
// RV32I execute stage: ID/EX register, MEM/WB operand forwarding, ALU,
// beq/jump resolution and EX/MEM register. ALU_ROR_EN enables rotate-right.
module alu_execute_stage
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  alu_execute_stage_if.slave  bus
);

  id_ex_t          id_ex;
  id_ex_t          id_ex_next;
  ex_mem_t         ex_mem;
  ex_mem_t         ex_mem_next;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b_reg;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            alu_illegal;

  // MEM is the younger producer, so it takes priority over WB; x0 never forwards
  function automatic logic [XLEN-1:0] forward_operand(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] reg_data,
    input logic            mem_we,
    input logic [4:0]      mem_dst,
    input logic [XLEN-1:0] mem_val,
    input logic            wb_we,
    input logic [4:0]      wb_dst,
    input logic [XLEN-1:0] wb_val
  );
    if (mem_we && (mem_dst == rs) && (rs != 5'd0)) return mem_val;
    if (wb_we && (wb_dst == rs) && (rs != 5'd0))   return wb_val;
    return reg_data;
  endfunction

  always_comb begin
    id_ex_next            = '0;
    id_ex_next.valid      = bus.id_valid;
    id_ex_next.ALUControl = bus.id_ALUControl;
    id_ex_next.rs1_data   = bus.id_rs1_data;
    id_ex_next.rs2_data   = bus.id_rs2_data;
    id_ex_next.imm        = bus.id_imm;
    id_ex_next.pc         = bus.id_pc;
    id_ex_next.rs1        = bus.id_rs1;
    id_ex_next.rs2        = bus.id_rs2;
    id_ex_next.rd         = bus.id_rd;
    id_ex_next.ALUSrc     = bus.id_ALUSrc;
    id_ex_next.RegWrite   = bus.id_RegWrite;
    id_ex_next.MemWrite   = bus.id_MemWrite;
    id_ex_next.Branch     = bus.id_Branch;
    id_ex_next.Jump       = bus.id_Jump;
    id_ex_next.ResultSrc  = bus.id_ResultSrc;
  end

  // Flush beats stall so a redirect can always kill the slot being fetched behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex <= '0;
    end else if (bus.flush_e) begin
      id_ex <= '0;
    end else if (!bus.stall_e) begin
      id_ex <= id_ex_next;
    end
  end

  assign src_a     = forward_operand(id_ex.rs1, id_ex.rs1_data,
                                     bus.mem_RegWrite, bus.mem_rd, bus.mem_fwd,
                                     bus.wb_RegWrite, bus.wb_rd, bus.wb_result);
  assign src_b_reg = forward_operand(id_ex.rs2, id_ex.rs2_data,
                                     bus.mem_RegWrite, bus.mem_rd, bus.mem_fwd,
                                     bus.wb_RegWrite, bus.wb_rd, bus.wb_result);
  assign src_b     = id_ex.ALUSrc ? id_ex.imm : src_b_reg;

  alu u_alu (
    .a          (src_a),
    .b          (src_b),
    .ALUControl (id_ex.ALUControl),
    .result     (alu_result),
    .zero       (alu_zero),
    .illegal    (alu_illegal)
  );

  always_comb begin
    ex_mem_next            = '0;
    ex_mem_next.valid      = id_ex.valid;
    ex_mem_next.RegWrite   = id_ex.RegWrite;
    ex_mem_next.MemWrite   = id_ex.MemWrite;
    ex_mem_next.ResultSrc  = id_ex.ResultSrc;
    ex_mem_next.alu_result = alu_result;
    ex_mem_next.write_data = src_b_reg;
    ex_mem_next.pc_plus4   = id_ex.pc + 32'd4;
    ex_mem_next.rd         = id_ex.rd;
  end

  // A stalled E slot is still sitting in ID/EX, so pass a bubble rather than a duplicate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem <= '0;
    end else if (bus.stall_e || !id_ex.valid) begin
      ex_mem <= '0;
    end else begin
      ex_mem <= ex_mem_next;
    end
  end

  assign bus.e_rs1        = id_ex.rs1;
  assign bus.e_rs2        = id_ex.rs2;
  assign bus.e_rd         = id_ex.rd;
  assign bus.e_ResultSrc0 = id_ex.ResultSrc[0];
  assign bus.pc_src_e     = id_ex.valid & ((id_ex.Branch & alu_zero) | id_ex.Jump);
  assign bus.pc_target_e  = id_ex.pc + id_ex.imm;
  assign bus.illegal_op_e = id_ex.valid & alu_illegal;

  assign bus.m_valid      = ex_mem.valid;
  assign bus.m_RegWrite   = ex_mem.RegWrite;
  assign bus.m_MemWrite   = ex_mem.MemWrite;
  assign bus.m_ResultSrc  = ex_mem.ResultSrc;
  assign bus.m_alu_result = ex_mem.alu_result;
  assign bus.m_write_data = ex_mem.write_data;
  assign bus.m_pc_plus4   = ex_mem.pc_plus4;
  assign bus.m_rd         = ex_mem.rd;

endmodule
